// File: rtl/equ_pkg.sv
// Shared types and defaults for the equalizer slot scheduler.
// The state encoding is fixed 3-bit binary so it is stable across tools.
package equ_pkg;

  localparam int NUM_SYM_DEF   = 7;
  localparam int DMRS_SYM_DEF  = 3;
  localparam int TO_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_CHEST = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_NEXT       = 3'd4,
    ST_DONE       = 3'd5,
    ST_ERR        = 3'd6
  } equ_state_e;

  // Next symbol index, hopping over the pilot symbol. Returned at 4 bits so
  // the caller can detect the end of the slot without 3-bit wrap.
  function automatic logic [3:0] next_sym(input logic [2:0] cur, input int dmrs);
    logic [3:0] s;
    s = {1'b0, cur} + 4'd1;
    if (s == 4'(dmrs)) s = s + 4'd1;
    return s;
  endfunction

endpackage

// File: rtl/equ_wdog_cnt.sv
// Watchdog counter: counts enabled cycles, flags expiry on the last allowed one.
module equ_wdog_cnt #(
  parameter int TO_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  logic [CW-1:0] cnt_q;

  assign o_expire = i_en && (cnt_q == CW'(TO_CYCLES - 1));

  // Saturates at the limit so a held enable cannot wrap back to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)          cnt_q <= '0;
    else if (i_en && !o_expire)  cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/equ_slot_sched.sv
// Per-slot scheduler launching one equalizer run per data symbol, skipping DMRS.
// Optional watchdog on the per-symbol wait: define EQU_SCHED_WDOG_EN.
module equ_slot_sched
  import equ_pkg::*;
#(
  parameter int NUM_SYM   = NUM_SYM_DEF,
  parameter int DMRS_SYM  = DMRS_SYM_DEF,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic       i_clk_equ,
  input  logic       i_rst,
  input  logic       i_start_slot,
  input  logic       i_chest_valid,
  input  logic       i_done_equ,
  output logic       o_start_equ,
  output logic [2:0] o_sym_idx,
  output logic       o_busy,
  output logic       o_done_slot,
  output logic       o_err_timeout
);

  equ_state_e state_q;
  logic [2:0] sym_q;
  logic [3:0] sym_nxt;
  logic       wdog_exp;

  assign sym_nxt = next_sym(sym_q, DMRS_SYM);

`ifdef EQU_SCHED_WDOG_EN
  logic err_q;

  equ_wdog_cnt #(.TO_CYCLES(TO_CYCLES)) u_wdog (
    .i_clk    (i_clk_equ),
    .i_rst    (i_rst),
    .i_clr    (state_q != ST_WAIT_DONE),
    .i_en     (state_q == ST_WAIT_DONE),
    .o_expire (wdog_exp)
  );

  // Sticky until the next accepted slot start; a done on the expiry cycle wins.
  always_ff @(posedge i_clk_equ) begin
    if (i_rst)                                             err_q <= 1'b0;
    else if (state_q == ST_IDLE && i_start_slot)           err_q <= 1'b0;
    else if (state_q == ST_WAIT_DONE && !i_done_equ && wdog_exp) err_q <= 1'b1;
  end

  assign o_err_timeout = err_q;
`else
  assign wdog_exp      = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk_equ) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      sym_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (i_start_slot) begin
          state_q <= ST_WAIT_CHEST;
          sym_q   <= '0;
        end
        ST_WAIT_CHEST: if (i_chest_valid) state_q <= ST_ISSUE;
        ST_ISSUE:      state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (i_done_equ)    state_q <= ST_NEXT;
          else if (wdog_exp) state_q <= ST_ERR;
        end
        ST_NEXT: begin
          sym_q   <= sym_nxt[2:0];
          state_q <= (sym_nxt >= 4'(NUM_SYM)) ? ST_DONE : ST_ISSUE;
        end
        ST_DONE: state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_start_equ = (state_q == ST_ISSUE);
  assign o_done_slot = (state_q == ST_DONE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_sym_idx   = sym_q;

endmodule

// File: tb/tb_equ_slot_sched.sv
// Randomized directed bench for equ_slot_sched against a symbol-list model.
module tb_equ_slot_sched;

  localparam int NS = 7;
  localparam int DM = 3;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst, start, chest, done;
  logic       o_start_equ, o_busy, o_done_slot, o_err_timeout;
  logic [2:0] o_sym_idx;

  int n_vec = 0;
  int n_err = 0;
  int starts = 0;
  int slots  = 0;

  equ_slot_sched dut (
    .i_clk_equ     (clk),
    .i_rst         (rst),
    .i_start_slot  (start),
    .i_chest_valid (chest),
    .i_done_equ    (done),
    .o_start_equ   (o_start_equ),
    .o_sym_idx     (o_sym_idx),
    .o_busy        (o_busy),
    .o_done_slot   (o_done_slot),
    .o_err_timeout (o_err_timeout)
  );

  always #5 clk = ~clk;

  // Pulse counters; a pulse stretched over two cycles counts twice.
  always @(negedge clk) begin
    if (o_start_equ) starts++;
    if (o_done_slot) slots++;
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference order: every symbol of the slot except the pilot.
  function automatic void data_syms(output int q[$]);
    q = {};
    for (int s = 0; s < NS; s++)
      if (s != DM) q.push_back(s);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, o_start_equ, 0);
    chk({tag, "_idx"},   o_sym_idx, 0);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_done"},  o_done_slot, 0);
    chk({tag, "_err"},   o_err_timeout, 0);
  endtask

  // cd: cycles chest stays low; dd_fix: fixed done delay (-1 random);
  // stray: inject ignored start/done pulses; abort_sym/hang_sym: -1 unused.
  task automatic run_slot(input int cd, input int dd_fix, input bit stray,
                          input int abort_sym, input int hang_sym);
    int q[$];
    int s0, d0, dd;
    data_syms(q);
    s0 = starts;
    d0 = slots;
    start = 1'b1; chest = 1'b0; step; start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    chk("err_clr_on_start", o_err_timeout, 0);
    for (int c = 0; c < cd; c++) begin
      chk("no_start_pre_chest", o_start_equ, 0);
      if (stray && c == 0) begin start = 1'b1; done = 1'b1; end
      step; start = 1'b0; done = 1'b0;
    end
    chest = 1'b1; step;
    foreach (q[i]) begin
      chk("start_pulse", o_start_equ, 1);
      chk("sym_idx", o_sym_idx, q[i]);
      step;
      if (stray) chest = 1'b0;
      chk("start_one_cycle", o_start_equ, 0);
      chk("busy_wait_done", o_busy, 1);
      if (q[i] == abort_sym) begin
        rst = 1'b1; step; rst = 1'b0;
        chk_all_zero("abort");
        chk("abort_no_done_slot", slots - d0, 0);
        return;
      end
      if (q[i] == hang_sym) begin
        for (int c = 0; c < TO; c++) begin
          chk("wdog_pre_err", o_err_timeout, 0);
          step;
        end
        chk("wdog_err_set", o_err_timeout, 1);
        chk("wdog_err_busy", o_busy, 1);
        step;
        chk("wdog_idle", o_busy, 0);
        chk("wdog_err_sticky", o_err_timeout, 1);
        step;
        chk("wdog_err_hold", o_err_timeout, 1);
        chk("wdog_no_done_slot", slots - d0, 0);
        return;
      end
      dd = (dd_fix >= 0) ? dd_fix : int'($urandom_range(0, 6));
      for (int c = 0; c < dd; c++) begin
        chk("hold_wait_done", o_start_equ, 0);
        if (stray && c == 0) start = 1'b1;
        step; start = 1'b0;
      end
      done = 1'b1; step; done = 1'b0;
      chk("next_no_start", o_start_equ, 0);
      step;
    end
    chk("done_slot", o_done_slot, 1);
    chk("done_no_start", o_start_equ, 0);
    step;
    chk("idle_busy", o_busy, 0);
    chk("done_one_cycle", o_done_slot, 0);
    chk("start_count", starts - s0, q.size());
    chk("slot_count", slots - d0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; chest = 1'b0; done = 1'b0;
    step; step;
    chk_all_zero("reset");
    rst = 1'b0; step;

    // Stray done while idle must not wake the block.
    done = 1'b1; step; done = 1'b0; step;
    chk("idle_stray_done", o_busy, 0);

    run_slot(0, 4, 1'b0, -1, -1);
    run_slot(10, -1, 1'b0, -1, -1);
    run_slot(3, -1, 1'b1, -1, -1);
    run_slot(0, -1, 1'b0, 4, -1);
    run_slot(0, -1, 1'b0, -1, -1);
    for (int r = 0; r < 8; r++)
      run_slot(int'($urandom_range(0, 5)), -1, 1'($urandom_range(0, 1)), -1, -1);

`ifdef EQU_SCHED_WDOG_EN
    run_slot(0, -1, 1'b0, -1, 2);
    run_slot(0, -1, 1'b0, -1, -1);
    run_slot(0, TO - 1, 1'b0, -1, -1);
    chk("expiry_done_wins", o_err_timeout, 0);
`else
    run_slot(0, 100, 1'b0, -1, -1);
    chk("no_wdog_err", o_err_timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
